// File: rtl/sys1_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sys1_input_ctrl
// Purpose  : SEGA System 1 player-input front end. Turns PS/2 key events and
//            joysticks into active-low INP0/INP1/INP2 bytes, with coin pulse
//            stretching counted in vblank frames.
// Revision : 1.0  initial release
// ============================================================================
module sys1_input_ctrl #(
    parameter int COIN_FRAMES  = 3,
    parameter bit SOCD_NEUTRAL = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystk1,
    input  logic [15:0] joystk2,
    input  logic        vblank,
    input  logic        bCabinet,
    output logic [7:0]  INP0,
    output logic [7:0]  INP1,
    output logic [7:0]  INP2
);

    localparam logic [4:0] c_K_U1   = 5'd0;
    localparam logic [4:0] c_K_D1   = 5'd1;
    localparam logic [4:0] c_K_L1   = 5'd2;
    localparam logic [4:0] c_K_R1   = 5'd3;
    localparam logic [4:0] c_K_T1_1 = 5'd4;
    localparam logic [4:0] c_K_T2_1 = 5'd5;
    localparam logic [4:0] c_K_F1   = 5'd6;
    localparam logic [4:0] c_K_F2   = 5'd7;
    localparam logic [4:0] c_K_S1   = 5'd8;
    localparam logic [4:0] c_K_S2   = 5'd9;
    localparam logic [4:0] c_K_C1   = 5'd10;
    localparam logic [4:0] c_K_C2   = 5'd11;
    localparam logic [4:0] c_K_U2   = 5'd12;
    localparam logic [4:0] c_K_D2   = 5'd13;
    localparam logic [4:0] c_K_L2   = 5'd14;
    localparam logic [4:0] c_K_R2   = 5'd15;
    localparam logic [4:0] c_K_T1_2 = 5'd16;
    localparam logic [4:0] c_K_T2_2 = 5'd17;

    localparam logic [3:0] c_COIN_FRAMES = 4'(COIN_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_WAIT_REL = 2'd2
    } coin_state_t;

    logic [17:0] r_keys;
    logic        r_toggle;
    logic        w_key_evt;
    logic        w_key_hit;
    logic [4:0]  w_key_idx;

    logic w_u1, w_d1, w_l1, w_r1, w_t1_1, w_t2_1;
    logic w_u2, w_d2, w_l2, w_r2, w_t1_2, w_t2_2;
    logic w_u1s, w_d1s, w_l1s, w_r1s, w_u2s, w_d2s, w_l2s, w_r2s;
    logic w_start1, w_start2, w_coin_raw;

    logic        r_vb_meta, r_vb_sync, r_vb_prev, w_vb_rise;
    logic        r_coin_raw, r_coin_prev, w_coin_rise;
    coin_state_t r_state, w_state_nxt;
    logic [3:0]  r_count, w_count_nxt, w_count_inc;
    logic        w_unused_bits;

    assign w_key_evt = ps2_key[10] ^ r_toggle;

    // Cursor keys match with or without the E0 prefix; all others need bit 8 clear.
    always_comb begin
        w_key_hit = 1'b0;
        w_key_idx = c_K_U1;
        case (ps2_key[7:0])
            8'h75: begin w_key_hit = 1'b1;         w_key_idx = c_K_U1;   end
            8'h72: begin w_key_hit = 1'b1;         w_key_idx = c_K_D1;   end
            8'h6B: begin w_key_hit = 1'b1;         w_key_idx = c_K_L1;   end
            8'h74: begin w_key_hit = 1'b1;         w_key_idx = c_K_R1;   end
            8'h29: begin w_key_hit = ~ps2_key[8];  w_key_idx = c_K_T1_1; end
            8'h14: begin w_key_hit = ~ps2_key[8];  w_key_idx = c_K_T2_1; end
            8'h05: begin w_key_hit = ~ps2_key[8];  w_key_idx = c_K_F1;   end
            8'h06: begin w_key_hit = ~ps2_key[8];  w_key_idx = c_K_F2;   end
            8'h16: begin w_key_hit = ~ps2_key[8];  w_key_idx = c_K_S1;   end
            8'h1E: begin w_key_hit = ~ps2_key[8];  w_key_idx = c_K_S2;   end
            8'h2E: begin w_key_hit = ~ps2_key[8];  w_key_idx = c_K_C1;   end
            8'h36: begin w_key_hit = ~ps2_key[8];  w_key_idx = c_K_C2;   end
            8'h2D: begin w_key_hit = ~ps2_key[8];  w_key_idx = c_K_U2;   end
            8'h2B: begin w_key_hit = ~ps2_key[8];  w_key_idx = c_K_D2;   end
            8'h23: begin w_key_hit = ~ps2_key[8];  w_key_idx = c_K_L2;   end
            8'h34: begin w_key_hit = ~ps2_key[8];  w_key_idx = c_K_R2;   end
            8'h1C: begin w_key_hit = ~ps2_key[8];  w_key_idx = c_K_T1_2; end
            8'h1B: begin w_key_hit = ~ps2_key[8];  w_key_idx = c_K_T2_2; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_keys   <= '0;
            r_toggle <= ps2_key[10];
        end else if (w_key_evt) begin
            r_toggle <= ps2_key[10];
            if (w_key_hit)
                r_keys[w_key_idx] <= ps2_key[9];
        end
    end

    assign w_u2   = r_keys[c_K_U2]   | joystk2[3];
    assign w_d2   = r_keys[c_K_D2]   | joystk2[2];
    assign w_l2   = r_keys[c_K_L2]   | joystk2[1];
    assign w_r2   = r_keys[c_K_R2]   | joystk2[0];
    assign w_t1_2 = r_keys[c_K_T1_2] | joystk2[4];
    assign w_t2_2 = r_keys[c_K_T2_2] | joystk2[5];

    // Upright cabinets share one control panel, so P2 also drives P1.
    assign w_u1   = r_keys[c_K_U1]   | joystk1[3] | (w_u2   & ~bCabinet);
    assign w_d1   = r_keys[c_K_D1]   | joystk1[2] | (w_d2   & ~bCabinet);
    assign w_l1   = r_keys[c_K_L1]   | joystk1[1] | (w_l2   & ~bCabinet);
    assign w_r1   = r_keys[c_K_R1]   | joystk1[0] | (w_r2   & ~bCabinet);
    assign w_t1_1 = r_keys[c_K_T1_1] | joystk1[4] | (w_t1_2 & ~bCabinet);
    assign w_t2_1 = r_keys[c_K_T2_1] | joystk1[5] | (w_t2_2 & ~bCabinet);

    assign w_start1   = r_keys[c_K_S1] | r_keys[c_K_F1] | joystk1[6] | joystk2[6];
    assign w_start2   = r_keys[c_K_S2] | r_keys[c_K_F2] | joystk1[7] | joystk2[7];
    assign w_coin_raw = r_keys[c_K_C1] | r_keys[c_K_C2] | r_keys[c_K_F1] | r_keys[c_K_F2]
                      | joystk1[8] | joystk2[8];

    always_comb begin
        w_u1s = w_u1; w_d1s = w_d1; w_l1s = w_l1; w_r1s = w_r1;
        w_u2s = w_u2; w_d2s = w_d2; w_l2s = w_l2; w_r2s = w_r2;
        if (SOCD_NEUTRAL) begin
            if (w_l1 && w_r1) begin w_l1s = 1'b0; w_r1s = 1'b0; end
            if (w_u1 && w_d1) begin w_u1s = 1'b0; w_d1s = 1'b0; end
            if (w_l2 && w_r2) begin w_l2s = 1'b0; w_r2s = 1'b0; end
            if (w_u2 && w_d2) begin w_u2s = 1'b0; w_d2s = 1'b0; end
        end
    end

    // Raw-coin history resets to "held" so a press spanning reset needs a release first.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_vb_meta   <= 1'b0;
            r_vb_sync   <= 1'b0;
            r_vb_prev   <= 1'b0;
            r_coin_raw  <= 1'b1;
            r_coin_prev <= 1'b1;
        end else begin
            r_vb_meta   <= vblank;
            r_vb_sync   <= r_vb_meta;
            r_vb_prev   <= r_vb_sync;
            r_coin_raw  <= w_coin_raw;
            r_coin_prev <= r_coin_raw;
        end
    end

    assign w_vb_rise   = r_vb_sync & ~r_vb_prev;
    assign w_coin_rise = r_coin_raw & ~r_coin_prev;
    assign w_count_inc = r_count + 4'd1;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_coin_rise) begin
                    w_state_nxt = ST_ACTIVE;
                    w_count_nxt = 4'd0;
                end
            end
            ST_ACTIVE: begin
                if (w_vb_rise) begin
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == c_COIN_FRAMES)
                        w_state_nxt = r_coin_raw ? ST_WAIT_REL : ST_IDLE;
                end
            end
            ST_WAIT_REL: begin
                if (!r_coin_raw)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            INP0 <= 8'hFF;
            INP1 <= 8'hFF;
            INP2 <= 8'hFF;
        end else begin
            INP0 <= ~{w_l1s, w_r1s, w_u1s, w_d1s, 1'b0, w_t2_1, w_t1_1, 1'b0};
            INP1 <= ~{w_l2s, w_r2s, w_u2s, w_d2s, 1'b0, w_t2_2, w_t1_2, 1'b0};
            INP2 <= ~{2'b00, w_start2, w_start1, 3'b000, (r_state == ST_ACTIVE)};
        end
    end

    assign w_unused_bits = ^{joystk1[15:9], joystk2[15:9]};

endmodule
`default_nettype wire

// File: tb/tb_sys1_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys1_input_ctrl
// Purpose  : Self-checking bench for sys1_input_ctrl: directed scenarios with
//            literal expectations plus randomized traffic against a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sys1_input_ctrl;

    localparam int COIN_FRAMES  = 3;
    localparam bit SOCD_NEUTRAL = 1'b1;

    localparam int B_U1 = 0,  B_D1 = 1,  B_L1 = 2,  B_R1 = 3,  B_T1_1 = 4,  B_T2_1 = 5;
    localparam int B_F1 = 6,  B_F2 = 7,  B_S1 = 8,  B_S2 = 9,  B_C1 = 10,   B_C2 = 11;
    localparam int B_U2 = 12, B_D2 = 13, B_L2 = 14, B_R2 = 15, B_T1_2 = 16, B_T2_2 = 17;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [15:0] joystk1 = '0;
    logic [15:0] joystk2 = '0;
    logic        vblank  = 1'b0;
    logic        bCabinet = 1'b0;
    logic [7:0]  INP0, INP1, INP2;

    int n_vec  = 0;
    int n_fail = 0;

    sys1_input_ctrl #(
        .COIN_FRAMES  (COIN_FRAMES),
        .SOCD_NEUTRAL (SOCD_NEUTRAL)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_key  (ps2_key),
        .joystk1  (joystk1),
        .joystk2  (joystk2),
        .vblank   (vblank),
        .bCabinet (bCabinet),
        .INP0     (INP0),
        .INP1     (INP1),
        .INP2     (INP2)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_btn [18];
    bit         m_tog, m_raw, m_raw_old, m_vb1, m_vb2, m_vb3, m_need_rel;
    int         m_frames;
    bit         m_valid = 1'b0;
    logic [7:0] exp0, exp1, exp2;

    function automatic int key_index(input logic [8:0] code);
        case (code[7:0])
            8'h75: return B_U1;
            8'h72: return B_D1;
            8'h6B: return B_L1;
            8'h74: return B_R1;
            default: ;
        endcase
        case (code)
            9'h029: return B_T1_1;  9'h014: return B_T2_1;
            9'h005: return B_F1;    9'h006: return B_F2;
            9'h016: return B_S1;    9'h01E: return B_S2;
            9'h02E: return B_C1;    9'h036: return B_C2;
            9'h02D: return B_U2;    9'h02B: return B_D2;
            9'h023: return B_L2;    9'h034: return B_R2;
            9'h01C: return B_T1_2;  9'h01B: return B_T2_2;
            default: return -1;
        endcase
    endfunction

    // Expected bytes (coin bit excluded) and raw coin from held keys and pads.
    function automatic void model_bytes(output logic [7:0] b0, output logic [7:0] b1,
                                        output logic [7:0] b2, output bit raw);
        bit u1, d1, l1, r1, t1a, t2a, u2, d2, l2, r2, t1b, t2b, share;
        share = !bCabinet;
        u2  = m_btn[B_U2]   || joystk2[3];
        d2  = m_btn[B_D2]   || joystk2[2];
        l2  = m_btn[B_L2]   || joystk2[1];
        r2  = m_btn[B_R2]   || joystk2[0];
        t1b = m_btn[B_T1_2] || joystk2[4];
        t2b = m_btn[B_T2_2] || joystk2[5];
        u1  = m_btn[B_U1]   || joystk1[3] || (share && u2);
        d1  = m_btn[B_D1]   || joystk1[2] || (share && d2);
        l1  = m_btn[B_L1]   || joystk1[1] || (share && l2);
        r1  = m_btn[B_R1]   || joystk1[0] || (share && r2);
        t1a = m_btn[B_T1_1] || joystk1[4] || (share && t1b);
        t2a = m_btn[B_T2_1] || joystk1[5] || (share && t2b);
        if (SOCD_NEUTRAL) begin
            if (l1 && r1) begin l1 = 0; r1 = 0; end
            if (u1 && d1) begin u1 = 0; d1 = 0; end
            if (l2 && r2) begin l2 = 0; r2 = 0; end
            if (u2 && d2) begin u2 = 0; d2 = 0; end
        end
        b0 = 8'hFF; b1 = 8'hFF; b2 = 8'hFF;
        if (l1) b0[7] = 0;  if (r1) b0[6] = 0;  if (u1) b0[5] = 0;  if (d1) b0[4] = 0;
        if (t2a) b0[2] = 0; if (t1a) b0[1] = 0;
        if (l2) b1[7] = 0;  if (r2) b1[6] = 0;  if (u2) b1[5] = 0;  if (d2) b1[4] = 0;
        if (t2b) b1[2] = 0; if (t1b) b1[1] = 0;
        if (m_btn[B_S2] || m_btn[B_F2] || joystk1[7] || joystk2[7]) b2[5] = 0;
        if (m_btn[B_S1] || m_btn[B_F1] || joystk1[6] || joystk2[6]) b2[4] = 0;
        raw = m_btn[B_C1] || m_btn[B_C2] || m_btn[B_F1] || m_btn[B_F2] || joystk1[8] || joystk2[8];
    endfunction

    always @(posedge clk_sys) begin
        logic [7:0] b0, b1, b2;
        bit raw_now, vb_rise, coin_rise;
        int idx;
        model_bytes(b0, b1, b2, raw_now);
        vb_rise   = m_vb2 && !m_vb3;
        coin_rise = m_raw && !m_raw_old;
        if (reset) begin
            exp0 = 8'hFF; exp1 = 8'hFF; exp2 = 8'hFF;
            m_valid = 1'b1;
            m_frames = 0; m_need_rel = 0;
            // A press visible during reset counts as already held.
            m_raw = 1; m_raw_old = 1;
            m_vb1 = 0; m_vb2 = 0; m_vb3 = 0;
            foreach (m_btn[i]) m_btn[i] = 0;
            m_tog = ps2_key[10];
        end else begin
            exp0 = b0;
            exp1 = b1;
            exp2 = (m_frames > 0) ? (b2 & 8'hFE) : b2;
            if (m_frames > 0) begin
                if (vb_rise) begin
                    m_frames--;
                    if (m_frames == 0 && m_raw) m_need_rel = 1;
                end
            end else if (m_need_rel) begin
                if (!m_raw) m_need_rel = 0;
            end else if (coin_rise) begin
                m_frames = COIN_FRAMES;
            end
            m_raw_old = m_raw;
            m_raw     = raw_now;
            m_vb3 = m_vb2; m_vb2 = m_vb1; m_vb1 = vblank;
            if (ps2_key[10] != m_tog) begin
                m_tog = ps2_key[10];
                idx = key_index(ps2_key[8:0]);
                if (idx >= 0) m_btn[idx] = ps2_key[9];
            end
        end
    end

    always @(negedge clk_sys) begin
        if (m_valid) begin
            check8("model INP0", INP0, exp0);
            check8("model INP1", INP1, exp1);
            check8("model INP2", INP2, exp2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_key(input bit pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    task automatic vb_pulse();
        vblank = 1'b1; cyc(4);
        vblank = 1'b0; cyc(4);
    endtask

    logic [8:0] codes [18] = '{9'h175, 9'h072, 9'h06B, 9'h174, 9'h029, 9'h014, 9'h005, 9'h006,
                               9'h016, 9'h01E, 9'h02E, 9'h036, 9'h02D, 9'h02B, 9'h023, 9'h034,
                               9'h01C, 9'h01B};

    initial begin
        logic [8:0] code;
        int vb_cnt;
        int idx;

        cyc(3);
        check8("reset INP0", INP0, 8'hFF);
        check8("reset INP2", INP2, 8'hFF);
        reset = 1'b0;
        cyc(2);

        // Up key (E0 75) press and release.
        send_key(1'b1, 9'h175);
        cyc(1);
        check8("up not early", INP0, 8'hFF);
        cyc(1);
        check8("up pressed", INP0, 8'hDF);
        send_key(1'b0, 9'h175);
        cyc(2);
        check8("up released", INP0, 8'hFF);

        // One-clock coin key press, frame-stretched pulse.
        send_key(1'b1, 9'h02E);
        cyc(1);
        send_key(1'b0, 9'h02E);
        cyc(4);
        check8("coin key pulse", INP2, 8'hFE);
        vb_pulse(); vb_pulse();
        check8("coin after 2 frames", INP2, 8'hFE);
        vb_pulse();
        check8("coin after 3 frames", INP2, 8'hFF);
        vb_pulse(); vb_pulse();
        check8("coin after 5 frames", INP2, 8'hFF);

        // Held joystick coin: one pulse, then re-press gives another.
        joystk1[8] = 1'b1;
        cyc(4);
        check8("held coin pulse", INP2, 8'hFE);
        repeat (10) vb_pulse();
        check8("held coin single", INP2, 8'hFF);
        joystk1[8] = 1'b0;
        cyc(4);
        joystk1[8] = 1'b1;
        cyc(4);
        check8("repress coin pulse", INP2, 8'hFE);
        repeat (3) vb_pulse();
        check8("repress coin end", INP2, 8'hFF);
        joystk1[8] = 1'b0;
        cyc(4);

        // F2 gives Start2 plus a coin.
        send_key(1'b1, 9'h006);
        cyc(2);
        check8("F2 start only", INP2, 8'hDF);
        cyc(2);
        check8("F2 start+coin", INP2, 8'hDE);
        send_key(1'b0, 9'h006);
        repeat (3) vb_pulse();
        check8("F2 released", INP2, 8'hFF);

        // Upright vs cocktail merge.
        bCabinet = 1'b0; joystk2[4] = 1'b1;
        cyc(2);
        check8("upright INP0", INP0, 8'hFD);
        check8("upright INP1", INP1, 8'hFD);
        bCabinet = 1'b1;
        cyc(2);
        check8("cocktail INP0", INP0, 8'hFF);
        check8("cocktail INP1", INP1, 8'hFD);
        joystk2 = '0; bCabinet = 1'b0;

        // Opposing directions cancel.
        joystk1 = 16'h0003;
        cyc(2);
        check8("socd L+R", INP0, 8'hFF);
        joystk1 = 16'h0002;
        cyc(2);
        check8("socd L only", INP0, 8'h7F);
        joystk1 = '0;
        cyc(2);

        // Reset during a pulse with coin held throughout.
        joystk1[8] = 1'b1;
        cyc(4);
        vb_pulse();
        check8("pre-reset pulse", INP2, 8'hFE);
        reset = 1'b1;
        cyc(1);
        check8("reset mid pulse", INP2, 8'hFF);
        cyc(1);
        reset = 1'b0;
        repeat (5) vb_pulse();
        check8("held across reset", INP2, 8'hFF);
        joystk1[8] = 1'b0;
        cyc(4);

        // Randomized traffic, checked every cycle by the model.
        vb_cnt = 10;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_sys);
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: code = 9'($urandom);
                    1: begin code = codes[$urandom_range(0, 17)]; code[8] = 1'($urandom_range(0, 1)); end
                    default: code = codes[$urandom_range(0, 17)];
                endcase
                send_key(1'($urandom_range(0, 1)), code);
            end
            if ($urandom_range(0, 29) == 0) begin
                idx = $urandom_range(0, 8);
                joystk1[idx] = ~joystk1[idx];
            end
            if ($urandom_range(0, 29) == 0) begin
                idx = $urandom_range(0, 8);
                joystk2[idx] = ~joystk2[idx];
            end
            if ($urandom_range(0, 399) == 0) bCabinet = ~bCabinet;
            if (vb_cnt == 0) begin
                vblank = ~vblank;
                vb_cnt = $urandom_range(2, 40);
            end else begin
                vb_cnt--;
            end
        end

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
